// File: rtl/constraint_pkg.sv
// Shared types and the per-beat combine/reduce function for the sequential
// constraint checker.
package constraint_pkg;

  // Widest beat the reduce function handles; narrower beats are zero-extended,
  // which is neutral for every mode (0|0, 0&0, 0^0 and 0|~0 all reduce harmlessly).
  localparam int MAX_WORD_W = 256;

  typedef enum logic [1:0] {
    MODE_OR_OR   = 2'b00,
    MODE_AND_OR  = 2'b01,
    MODE_XOR_OR  = 2'b10,
    MODE_ORN_AND = 2'b11
  } mode_e;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_REPORT  = 1'b1
  } state_e;

  function automatic logic beat_reduce(input logic [MAX_WORD_W-1:0] data,
                                       input logic [MAX_WORD_W-1:0] mask,
                                       input mode_e                 mode);
    logic r;
    case (mode)
      MODE_OR_OR:  r = |(data | mask);
      MODE_AND_OR: r = |(data & mask);
      MODE_XOR_OR: r = |(data ^ mask);
      default:     r = &(data | ~mask);
    endcase
    return r;
  endfunction

  function automatic logic mode_is_and(input mode_e mode);
    return mode == MODE_ORN_AND;
  endfunction

endpackage

// File: rtl/constraint_lane.sv
// One constraint channel: accumulator, started/done/mode bookkeeping and the
// per-beat protocol error detection for that channel.
module constraint_lane
  import constraint_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              clear,
  input  logic [WORD_W-1:0] data,
  input  logic [WORD_W-1:0] mask,
  input  mode_e             mode,
  input  logic              last,
  output logic              beat_err,
  output logic              acc_nxt,
  output logic              done_nxt
);

  logic  acc_q;
  logic  done_q;
  logic  started_q;
  mode_e mode_q;
  logic  red;

  assign red = beat_reduce(MAX_WORD_W'(data), MAX_WORD_W'(mask), mode);

  // The first beat seeds the accumulator with its own reduction, which equals
  // 0 OR r for the OR modes and 1 AND r for the AND mode.
  always_comb begin
    beat_err = sel && (done_q || (started_q && (mode != mode_q)));
    acc_nxt  = acc_q;
    done_nxt = done_q;
    if (sel && !beat_err) begin
      if (!started_q)
        acc_nxt = red;
      else if (mode_is_and(mode_q))
        acc_nxt = acc_q & red;
      else
        acc_nxt = acc_q | red;
      done_nxt = done_q | last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= 1'b0;
      done_q    <= 1'b0;
      started_q <= 1'b0;
      mode_q    <= MODE_OR_OR;
    end else if (clear) begin
      acc_q     <= 1'b0;
      done_q    <= 1'b0;
      started_q <= 1'b0;
      mode_q    <= MODE_OR_OR;
    end else if (sel && !beat_err) begin
      acc_q     <= acc_nxt;
      done_q    <= done_nxt;
      started_q <= 1'b1;
      if (!started_q)
        mode_q <= mode;
    end
  end

endmodule

// File: rtl/constraint_reduce_seq.sv
// Multi-channel sequential OR/AND-reduction constraint checker: collects beats
// per channel, then reports per-channel results and their conjunction.
module constraint_reduce_seq
  import constraint_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CH_W-1:0]   s_ch,
  input  logic [WORD_W-1:0] s_data,
  input  logic [WORD_W-1:0] s_mask,
  input  logic [1:0]        s_mode,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_x,
  output logic [NUM_CH-1:0] m_res,
  output logic              m_err
);

  state_e state_q, state_d;
  logic   fire;
  logic   handshake;
  logic   ch_bad;
  logic   err_q;
  logic   err_nxt;
  logic   [NUM_CH-1:0] sel;
  logic   [NUM_CH-1:0] lane_err;
  logic   [NUM_CH-1:0] acc_nxt;
  logic   [NUM_CH-1:0] done_nxt;

  assign s_ready   = (state_q == ST_COLLECT);
  assign m_valid   = (state_q == ST_REPORT);
  assign fire      = s_valid && s_ready;
  assign handshake = m_valid && m_ready;

  // Out-of-range ids are only representable when NUM_CH is not a power of two.
  if (NUM_CH < (1 << CH_W)) begin : g_range_check
    assign ch_bad = int'(s_ch) >= NUM_CH;
  end else begin : g_no_range_check
    assign ch_bad = 1'b0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign sel[i] = fire && !ch_bad && (s_ch == CH_W'(i));

    constraint_lane #(.WORD_W(WORD_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel[i]),
      .clear    (handshake),
      .data     (s_data),
      .mask     (s_mask),
      .mode     (mode_e'(s_mode)),
      .last     (s_last),
      .beat_err (lane_err[i]),
      .acc_nxt  (acc_nxt[i]),
      .done_nxt (done_nxt[i])
    );
  end

  assign err_nxt = err_q | (fire && (ch_bad || (|lane_err)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_COLLECT;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (fire && (&done_nxt)) state_d = ST_REPORT;
      ST_REPORT:  if (m_ready)             state_d = ST_COLLECT;
      default:                             state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (handshake)
      err_q <= 1'b0;
    else
      err_q <= err_nxt;
  end

  // Results are captured on the completing beat and frozen until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res <= '0;
      m_x   <= 1'b0;
      m_err <= 1'b0;
    end else if (handshake) begin
      m_res <= '0;
      m_x   <= 1'b0;
      m_err <= 1'b0;
    end else if ((state_q == ST_COLLECT) && (state_d == ST_REPORT)) begin
      m_res <= acc_nxt;
      m_x   <= &acc_nxt;
      m_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_constraint_reduce_seq.sv
// Scoreboard bench for constraint_reduce_seq: directed frames push expected
// reports into a queue that a monitor checks whenever m_valid rises.
module tb_constraint_reduce_seq;

  localparam int WORD_W = 64;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [NUM_CH-1:0] res;
    logic              x;
    logic              err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [CH_W-1:0]   s_ch = '0;
  logic [WORD_W-1:0] s_data = '0;
  logic [WORD_W-1:0] s_mask = '0;
  logic [1:0]        s_mode = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic              m_x;
  logic [NUM_CH-1:0] m_res;
  logic              m_err;

  exp_t exp_q[$];
  exp_t mon_exp;
  int   checks = 0;
  int   passed = 0;
  int   pushed = 0;
  int   reports = 0;
  logic seen = 1'b0;

  always #5 clk = ~clk;

  constraint_reduce_seq #(.WORD_W(WORD_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_ch    (s_ch),
    .s_data  (s_data),
    .s_mask  (s_mask),
    .s_mode  (s_mode),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_x     (m_x),
    .m_res   (m_res),
    .m_err   (m_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected)
      passed++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic expectReport(input logic [NUM_CH-1:0] res, input logic err);
    exp_t e;
    e.res = res;
    e.x   = &res;
    e.err = err;
    exp_q.push_back(e);
    pushed++;
  endtask

  // Drives one beat from a falling edge and returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [63:0] data,
                               input logic [63:0] mask, input logic [1:0] mode,
                               input logic last);
    int wait_cnt;
    @(negedge clk);
    s_valid = 1'b1;
    s_ch    = ch;
    s_data  = data;
    s_mask  = mask;
    s_mode  = mode;
    s_last  = last;
    wait_cnt = 0;
    while (!s_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!s_ready) begin
      checks++;
      $display("[TB] FAIL s_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitIdle();
    int cnt = 0;
    while ((exp_q.size() != 0 || m_valid) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (exp_q.size() != 0 || m_valid) begin
      checks++;
      $display("[TB] FAIL report_timeout: got pending %0d expected 0", exp_q.size());
    end
  endtask

  task automatic fillOnes(input int first_ch);
    for (int c = first_ch; c < NUM_CH; c++)
      applyStimulus(CH_W'(c), 64'h1, 64'h0, 2'b00, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst_n || !m_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      reports++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_report: got m_res %0h expected none", m_res);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("m_res", 64'(m_res), 64'(mon_exp.res));
        checkOutput("m_x",   64'(m_x),   64'(mon_exp.x));
        checkOutput("m_err", 64'(m_err), 64'(mon_exp.err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_m_valid", 64'(m_valid), 64'h0);
    checkOutput("rst_m_res",   64'(m_res),   64'h0);
    checkOutput("rst_m_x",     64'(m_x),     64'h0);
    checkOutput("rst_m_err",   64'(m_err),   64'h0);
    checkOutput("rst_s_ready", 64'(s_ready), 64'h1);
    rst_n = 1'b1;

    // Mode 00, one-beat operand: nonzero mask alone makes the OR true.
    expectReport(4'b1111, 1'b0);
    applyStimulus(2'd0, 64'h0, 64'h0079e95d6d76cb31, 2'b00, 1'b1);
    applyStimulus(2'd1, 64'h1, 64'h0, 2'b00, 1'b1);
    applyStimulus(2'd2, 64'h1, 64'h0, 2'b00, 1'b1);
    checkOutput("pre_last_m_valid", 64'(m_valid), 64'h0);
    applyStimulus(2'd3, 64'h1, 64'h0, 2'b00, 1'b1);
    checkOutput("latency_m_valid", 64'(m_valid), 64'h1);
    waitIdle();

    // Mode 11 with mask all-ones makes data|~mask == data, so bit 0 clear -> 0.
    expectReport(4'b1110, 1'b0);
    applyStimulus(2'd0, ONES, ONES, 2'b11, 1'b0);
    applyStimulus(2'd0, 64'hFFFF_FFFF_FFFF_FFFE, ONES, 2'b11, 1'b1);
    fillOnes(1);
    waitIdle();
    expectReport(4'b1111, 1'b0);
    applyStimulus(2'd0, ONES, ONES, 2'b11, 1'b0);
    applyStimulus(2'd0, ONES, ONES, 2'b11, 1'b1);
    fillOnes(1);
    waitIdle();

    // Interleaved channels with mixed modes.
    expectReport(4'b0101, 1'b0);
    applyStimulus(2'd2, 64'hF0, 64'hF0, 2'b10, 1'b0);
    applyStimulus(2'd0, 64'h0,  64'h0,  2'b00, 1'b0);
    applyStimulus(2'd3, 64'h0,  64'h0,  2'b00, 1'b0);
    applyStimulus(2'd1, 64'h0F, 64'hF0, 2'b01, 1'b0);
    applyStimulus(2'd2, 64'h1,  64'h0,  2'b10, 1'b1);
    applyStimulus(2'd0, 64'h0,  64'h8000_0000_0000_0000, 2'b00, 1'b1);
    applyStimulus(2'd1, 64'h3,  64'h4,  2'b01, 1'b1);
    checkOutput("interleave_pre_m_valid", 64'(m_valid), 64'h0);
    applyStimulus(2'd3, 64'h0,  64'h0,  2'b00, 1'b1);
    checkOutput("interleave_m_valid", 64'(m_valid), 64'h1);
    waitIdle();

    // Backpressure: report held for 5 cycles while a beat is offered.
    m_ready = 1'b0;
    expectReport(4'b1111, 1'b0);
    fillOnes(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_ch    = 2'd0;
      s_data  = 64'h0;
      s_mask  = 64'h0;
      s_mode  = 2'b01;
      s_last  = 1'b1;
      checkOutput("hold_s_ready", 64'(s_ready), 64'h0);
      checkOutput("hold_m_valid", 64'(m_valid), 64'h1);
      checkOutput("hold_m_res",   64'(m_res),   64'hF);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    waitIdle();

    // Protocol errors: mode change mid-channel and a beat to a done channel.
    expectReport(4'b0110, 1'b1);
    applyStimulus(2'd0, 64'h0, 64'h0, 2'b00, 1'b0);
    applyStimulus(2'd0, 64'h1, 64'h1, 2'b01, 1'b0);
    applyStimulus(2'd0, 64'h0, 64'h0, 2'b00, 1'b1);
    applyStimulus(2'd0, 64'h1, 64'h0, 2'b00, 1'b1);
    applyStimulus(2'd1, 64'h1, 64'h0, 2'b00, 1'b1);
    applyStimulus(2'd2, ONES,  64'h0, 2'b11, 1'b1);
    applyStimulus(2'd3, 64'h0, 64'h0, 2'b00, 1'b1);
    waitIdle();
    expectReport(4'b1111, 1'b0);
    fillOnes(0);
    waitIdle();

    // Reset mid-frame after three channels are done.
    applyStimulus(2'd0, 64'h1, 64'h0, 2'b00, 1'b1);
    applyStimulus(2'd1, 64'h1, 64'h0, 2'b00, 1'b1);
    applyStimulus(2'd2, 64'h1, 64'h0, 2'b00, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_m_valid", 64'(m_valid), 64'h0);
    checkOutput("midrst_s_ready", 64'(s_ready), 64'h1);
    rst_n = 1'b1;
    expectReport(4'b1101, 1'b0);
    applyStimulus(2'd0, 64'h1, 64'h0, 2'b00, 1'b1);
    applyStimulus(2'd1, 64'h0, 64'h0, 2'b01, 1'b1);
    applyStimulus(2'd2, 64'h1, 64'h0, 2'b00, 1'b1);
    checkOutput("postrst_pre_m_valid", 64'(m_valid), 64'h0);
    applyStimulus(2'd3, 64'h1, 64'h0, 2'b00, 1'b1);
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("report_count", 64'(reports), 64'(pushed));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
